vdma_wr_req_arbiter: RTL and testbench

Shares one AXI write-burst engine between NCH fifo_status_ctrl-style requesters, e.g. per-stream VDMA write channels. Each requester raises burst_req or tail_req with req_len. The arbiter picks one requester round-robin, with tail requests taking precedence over burst requests. It issues a single command to the engine and routes one-cycle resp/done pulses back to the granted requester. It sits between the per-stream status controllers and the AXI write master.

---
 rtl/vdma_arb_pkg.sv | 16 +
 rtl/vdma_wr_req_arbiter_if.sv | 41 ++++
 rtl/rr_pick.sv | 31 +++
 rtl/vdma_wr_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vdma_wr_req_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vdma_arb_pkg.sv
// Purpose : shared types and constants for the VDMA write-request arbiter.
// Contents: arbiter state enum, timeout counter width and default timeout.
package vdma_arb_pkg;

    localparam int unsigned TO_W = 24;

    localparam logic [TO_W-1:0] ARB_TO_DEFAULT = 24'hFFF000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        FIN   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vdma_wr_req_arbiter_if.sv
// Purpose : bundle of requester-side and engine-side signals of the arbiter.
// Ports   : master = arbiter side, slave = requesters + engine + control.
//   enable, err_clr          control inputs to the arbiter
//   burst_req/tail_req/req_len  per-channel requests (level, held until resp)
//   resp/done                one-cycle per-channel pulses back to requesters
//   cmd_valid/cmd_ready/cmd_ch/cmd_len/cmd_tail  command to the engine
//   eng_done                 engine completion pulse
//   busy, timeout_err        status
interface vdma_wr_req_arbiter_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned LSIZE = 9
);
    localparam int unsigned CW = $clog2(NCH);

    logic                   enable;
    logic [NCH-1:0]         burst_req;
    logic [NCH-1:0]         tail_req;
    logic [NCH*LSIZE-1:0]   req_len;
    logic [NCH-1:0]         resp;
    logic [NCH-1:0]         done;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [CW-1:0]          cmd_ch;
    logic [LSIZE-1:0]       cmd_len;
    logic                   cmd_tail;
    logic                   eng_done;
    logic                   busy;
    logic                   timeout_err;
    logic                   err_clr;

    modport master (
        input  enable, burst_req, tail_req, req_len, cmd_ready, eng_done, err_clr,
        output resp, done, cmd_valid, cmd_ch, cmd_len, cmd_tail, busy, timeout_err
    );

    modport slave (
        output enable, burst_req, tail_req, req_len, cmd_ready, eng_done, err_clr,
        input  resp, done, cmd_valid, cmd_ch, cmd_len, cmd_tail, busy, timeout_err
    );

endinterface

// File: rtl/rr_pick.sv
// Purpose : combinational round-robin picker.
// Ports   : i_req     request vector
//           i_last    index of the previously granted requester
//           o_grant_c first set request searching i_last+1, i_last+2, ... mod N
//           o_any_c   any request set
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_grant_c,
    output logic         o_any_c
);

    // Scan offsets 1..N; the first hit wins, offset N wraps back to i_last.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        o_grant_c = '0;
        o_any_c   = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(i_last) + i) % N;
            if (!o_any_c && i_req[idx[W-1:0]]) begin
                o_grant_c = W'(idx);
                o_any_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdma_wr_req_arbiter.sv
// Purpose : shares one AXI write-burst engine between NCH requesters.
//           Tail requests take precedence over burst requests; within the
//           chosen set the grant rotates round-robin. One command in flight.
// Ports   : clock, rst_n (async active-low)
//           bus : vdma_wr_req_arbiter_if.master (requests, command, status)
module vdma_wr_req_arbiter
    import vdma_arb_pkg::*;
#(
    parameter int unsigned     NCH       = 4,
    parameter int unsigned     LSIZE     = 9,
    parameter logic [TO_W-1:0] TO_CYCLES = ARB_TO_DEFAULT
) (
    input  logic                  clock,
    input  logic                  rst_n,
    vdma_wr_req_arbiter_if.master bus
);

    localparam int unsigned CW    = $clog2(NCH);
    localparam int unsigned CNT_X = TO_W + 1;

    arb_state_e       r_state, w_nxt_state;
    logic [CW-1:0]    r_ch, w_nxt_ch;
    logic [CW-1:0]    r_last, w_nxt_last;
    logic [LSIZE-1:0] r_len, w_nxt_len;
    logic             r_tail, w_nxt_tail;
    logic [TO_W-1:0]  r_cnt, w_nxt_cnt;
    logic             r_to_err, w_nxt_to_err;
    logic [NCH-1:0]   r_resp, w_nxt_resp;
    logic [NCH-1:0]   r_done, w_nxt_done;
    logic             r_cmd_valid;
    logic             r_busy;

    logic             w_tail_any;
    logic [NCH-1:0]   w_cand;
    logic [CW-1:0]    w_pick;
    logic             w_any;
    logic [LSIZE-1:0] w_pick_len;
    logic [NCH-1:0]   w_ch_onehot;
    logic             w_set_to;
    logic             w_to_hit;

    // Any pending tail request masks all burst requests.
    assign w_tail_any  = |bus.tail_req;
    assign w_cand      = w_tail_any ? bus.tail_req : bus.burst_req;
    assign w_ch_onehot = NCH'(1) << r_ch;
    assign w_to_hit    = ({1'b0, r_cnt} + CNT_X'(1)) >= {1'b0, TO_CYCLES};

    rr_pick #(
        .N (NCH),
        .W (CW)
    ) u_pick (
        .i_req     (w_cand),
        .i_last    (r_last),
        .o_grant_c (w_pick),
        .o_any_c   (w_any)
    );

    // Length slice of the picked channel.
    always_comb begin
        w_pick_len = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_pick == CW'(i)) begin
                w_pick_len = bus.req_len[i*LSIZE +: LSIZE];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ch     = r_ch;
        w_nxt_len    = r_len;
        w_nxt_tail   = r_tail;
        w_nxt_last   = r_last;
        w_nxt_cnt    = r_cnt;
        w_nxt_resp   = '0;
        w_nxt_done   = '0;
        w_set_to     = 1'b0;
        w_nxt_to_err = r_to_err;

        case (r_state)
            IDLE: begin
                if (bus.enable && w_any) begin
                    w_nxt_ch    = w_pick;
                    w_nxt_len   = w_pick_len;
                    w_nxt_tail  = w_tail_any;
                    w_nxt_state = ISSUE;
                end
            end
            ISSUE: begin
                // cmd_valid is high throughout ISSUE, so ready alone completes the handshake.
                if (bus.cmd_ready) begin
                    w_nxt_state = BUSY;
                    w_nxt_resp  = w_ch_onehot;
                    w_nxt_last  = r_ch;
                    w_nxt_cnt   = '0;
                end
            end
            BUSY: begin
                if (bus.eng_done) begin
                    w_nxt_state = FIN;
                    w_nxt_done  = w_ch_onehot;
                end else if (w_to_hit) begin
                    w_nxt_state = IDLE;
                    w_set_to    = 1'b1;
                end else if (r_cnt != '1) begin
                    w_nxt_cnt = r_cnt + TO_W'(1);
                end
            end
            FIN: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        // Clearing wins over a timeout raised in the same cycle.
        if (bus.err_clr) begin
            w_nxt_to_err = 1'b0;
        end else if (w_set_to) begin
            w_nxt_to_err = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_len       <= '0;
            r_tail      <= 1'b0;
            r_last      <= CW'(NCH - 1);
            r_cnt       <= '0;
            r_to_err    <= 1'b0;
            r_resp      <= '0;
            r_done      <= '0;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ch        <= w_nxt_ch;
            r_len       <= w_nxt_len;
            r_tail      <= w_nxt_tail;
            r_last      <= w_nxt_last;
            r_cnt       <= w_nxt_cnt;
            r_to_err    <= w_nxt_to_err;
            r_resp      <= w_nxt_resp;
            r_done      <= w_nxt_done;
            r_cmd_valid <= (w_nxt_state == ISSUE);
            r_busy      <= (w_nxt_state != IDLE);
        end
    end

    assign bus.resp        = r_resp;
    assign bus.done        = r_done;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_ch      = r_ch;
    assign bus.cmd_len     = r_len;
    assign bus.cmd_tail    = r_tail;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_to_err;

endmodule

// File: tb/tb_vdma_wr_req_arbiter.sv
// Purpose : directed self-checking bench for vdma_wr_req_arbiter.
//           NCH=4, LSIZE=9, TO_CYCLES=100.
module tb_vdma_wr_req_arbiter;

    logic clock;
    logic rst_n;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [8:0] lens [4];

    vdma_wr_req_arbiter_if #(.NCH(4), .LSIZE(9)) bus ();

    vdma_wr_req_arbiter #(
        .NCH       (4),
        .LSIZE     (9),
        .TO_CYCLES (24'd100)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] onehot(input int ch);
        return 32'(1) << ch;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid();
        int unsigned k = 0;
        while (!bus.cmd_valid && k < 20) begin
            step();
            k++;
        end
        chk("cmd_valid_wait", 32'(bus.cmd_valid), 32'(1));
    endtask

    // From the resp cycle: engine finishes a few cycles later, done follows.
    task automatic finish_xfer(input int ch);
        repeat (2) step();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("done", 32'(bus.done), onehot(ch));
    endtask

    task automatic xfer(input int ch, input logic tail, input logic reassert);
        wait_valid();
        chk("xfer_ch", 32'(bus.cmd_ch), 32'(ch));
        chk("xfer_len", 32'(bus.cmd_len), 32'(lens[ch]));
        chk("xfer_tail", 32'(bus.cmd_tail), 32'(tail));
        step();
        chk("xfer_resp", 32'(bus.resp), onehot(ch));
        bus.burst_req[ch] = 1'b0;
        bus.tail_req[ch]  = 1'b0;
        finish_xfer(ch);
        if (reassert) bus.burst_req[ch] = 1'b1;
    endtask

    initial begin
        int unsigned n_done;

        lens[0] = 9'd17;
        lens[1] = 9'd33;
        lens[2] = 9'd0;
        lens[3] = 9'd511;

        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.burst_req = '0;
        bus.tail_req  = '0;
        bus.req_len   = '0;
        bus.cmd_ready = 1'b0;
        bus.eng_done  = 1'b0;
        bus.err_clr   = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'(0));
        chk("rst_resp", 32'(bus.resp), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_to_err", 32'(bus.timeout_err), 32'(0));
        chk("rst_cmd_ch", 32'(bus.cmd_ch), 32'(0));
        chk("rst_cmd_len", 32'(bus.cmd_len), 32'(0));

        // Basic transfer with exact latency: burst 0110, last=3 -> ch1
        repeat (3) @(posedge clock);
        #1;
        rst_n         = 1'b1;
        bus.req_len   = {lens[3], lens[2], lens[1], lens[0]};
        bus.enable    = 1'b1;
        bus.cmd_ready = 1'b1;
        bus.burst_req = 4'b0110;
        step();
        chk("t1_cmd_valid", 32'(bus.cmd_valid), 32'(1));
        chk("t1_cmd_ch", 32'(bus.cmd_ch), 32'(1));
        chk("t1_cmd_len", 32'(bus.cmd_len), 32'(33));
        chk("t1_cmd_tail", 32'(bus.cmd_tail), 32'(0));
        chk("t1_busy", 32'(bus.busy), 32'(1));
        step();
        chk("t1_resp", 32'(bus.resp), 32'(4'b0010));
        chk("t1_cmd_valid_low", 32'(bus.cmd_valid), 32'(0));
        bus.burst_req[1] = 1'b0;
        repeat (4) step();
        chk("t1_no_early_done", 32'(bus.done), 32'(0));
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("t1_done", 32'(bus.done), 32'(4'b0010));
        xfer(2, 1'b0, 1'b0);    // next grant ch2, req_len=0 forwarded

        // Full rotation from reset: 0,1,2,3,0
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        rst_n         = 1'b1;
        bus.burst_req = 4'b1111;
        xfer(0, 1'b0, 1'b1);
        xfer(1, 1'b0, 1'b1);
        xfer(2, 1'b0, 1'b1);
        xfer(3, 1'b0, 1'b1);
        xfer(0, 1'b0, 1'b0);
        bus.burst_req = '0;

        // Tail precedence; channel with both bits counts as tail
        bus.burst_req = 4'b0001;
        bus.tail_req  = 4'b0100;
        xfer(2, 1'b1, 1'b0);
        xfer(0, 1'b0, 1'b0);
        bus.burst_req = 4'b1010;
        bus.tail_req  = 4'b0010;
        xfer(1, 1'b1, 1'b0);
        xfer(3, 1'b0, 1'b0);

        // Back-pressure: fields held while ready low, despite request drop
        bus.cmd_ready = 1'b0;
        bus.burst_req = 4'b0001;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 3) begin
                bus.burst_req   = '0;
                bus.enable      = 1'b0;
                bus.req_len[8:0] = 9'd5;
            end
            chk("bp_cmd_valid", 32'(bus.cmd_valid), 32'(1));
            chk("bp_cmd_ch", 32'(bus.cmd_ch), 32'(0));
            chk("bp_cmd_len", 32'(bus.cmd_len), 32'(17));
            chk("bp_no_resp", 32'(bus.resp), 32'(0));
        end
        bus.cmd_ready = 1'b1;
        step();
        chk("bp_resp", 32'(bus.resp), 32'(4'b0001));
        bus.enable  = 1'b1;
        bus.req_len = {lens[3], lens[2], lens[1], lens[0]};
        finish_xfer(0);

        // eng_done while idle is ignored
        repeat (2) step();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("idle_eng_done", 32'(bus.done), 32'(0));
        chk("idle_busy", 32'(bus.busy), 32'(0));
        step();
        chk("idle_eng_done2", 32'(bus.done), 32'(0));

        // Timeout after 100 BUSY cycles
        bus.burst_req = 4'b0100;
        wait_valid();
        chk("to_cmd_ch", 32'(bus.cmd_ch), 32'(2));
        step();
        chk("to_resp", 32'(bus.resp), 32'(4'b0100));
        bus.burst_req = '0;
        n_done = 0;
        repeat (99) begin
            step();
            if (bus.done != '0) n_done++;
        end
        chk("to_busy_before", 32'(bus.busy), 32'(1));
        chk("to_err_before", 32'(bus.timeout_err), 32'(0));
        step();
        if (bus.done != '0) n_done++;
        chk("to_busy_after", 32'(bus.busy), 32'(0));
        chk("to_err_set", 32'(bus.timeout_err), 32'(1));
        chk("to_no_done", 32'(n_done), 32'(0));
        step();
        chk("to_err_sticky", 32'(bus.timeout_err), 32'(1));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("to_err_clr", 32'(bus.timeout_err), 32'(0));
        // last moved to ch2 despite the timeout: search 3,0 -> ch0
        bus.burst_req = 4'b0011;
        xfer(0, 1'b0, 1'b0);
        xfer(1, 1'b0, 1'b0);

        // Asynchronous reset mid-transfer, then re-arbitration from last=3
        bus.burst_req = 4'b1001;
        wait_valid();
        chk("ar_cmd_ch", 32'(bus.cmd_ch), 32'(3));
        step();
        chk("ar_resp", 32'(bus.resp), 32'(4'b1000));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_resp0", 32'(bus.resp), 32'(0));
        chk("ar_busy0", 32'(bus.busy), 32'(0));
        chk("ar_valid0", 32'(bus.cmd_valid), 32'(0));
        chk("ar_ch0", 32'(bus.cmd_ch), 32'(0));
        chk("ar_len0", 32'(bus.cmd_len), 32'(0));
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        xfer(0, 1'b0, 1'b0);
        xfer(3, 1'b0, 1'b0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
